rx_cal_tx: RTL

Initiator (TX-side) half of the MBTRAIN RX-calibration handshake. When enabled it sends the start request over the sideband and waits for the partner's start response. It then holds for a fixed calibration window, sends the end request and waits for the end response before raising a done acknowledge. It shares the sideband message mux with the RX-side responder, so it arbitrates its valid strobe against the responder's valid and drops it on the sideband serializer's busy falling edge.

---
 rtl/rx_cal_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rx_cal_tx.sv
// Initiator half of the MBTRAIN RX-calibration handshake: start req/resp, a fixed
// calibration window, end req/resp, then a done acknowledge held until enable drops.
module rx_cal_tx #(
  parameter int unsigned CAL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_decoded_sideband_message,
  input  logic       i_sideband_valid,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_rx,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_tx,
  output logic       o_test_ack
);

  localparam int unsigned MSG_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [MSG_W-1:0] MSG_NONE       = MSG_W'(4'b0000);
  localparam logic [MSG_W-1:0] MSG_START_REQ  = MSG_W'(4'b0001);
  localparam logic [MSG_W-1:0] MSG_START_RESP = MSG_W'(4'b0010);
  localparam logic [MSG_W-1:0] MSG_END_REQ    = MSG_W'(4'b0011);
  localparam logic [MSG_W-1:0] MSG_END_RESP   = MSG_W'(4'b0100);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_START_REQ,
    WAIT_START_RESP,
    CAL_WAIT,
    SEND_END_REQ,
    WAIT_END_RESP,
    TEST_FINISHED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  logic start_resp, end_resp, own_busy;

  assign start_resp = i_sideband_valid && (i_decoded_sideband_message == MSG_START_RESP);
  assign end_resp   = i_sideband_valid && (i_decoded_sideband_message == MSG_END_RESP);
  // A busy pulse only belongs to us while our own valid is on the mux.
  assign own_busy   = i_busy_negedge_detected && o_valid_tx;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      state              <= IDLE;
      o_sideband_message <= MSG_NONE;
      o_valid_tx         <= 1'b0;
      o_test_ack         <= 1'b0;
      cnt                <= '0;
      pending            <= 1'b0;
    end else begin
      // Deferred request: raise valid on the first cycle the responder leaves the mux.
      if (pending && !i_valid_rx) begin
        o_valid_tx <= 1'b1;
        pending    <= 1'b0;
      end

      case (state)
        IDLE: begin
          state              <= SEND_START_REQ;
          o_sideband_message <= MSG_START_REQ;
          if (i_valid_rx) pending    <= 1'b1;
          else            o_valid_tx <= 1'b1;
        end

        SEND_START_REQ: begin
          if (own_busy) begin
            o_valid_tx <= 1'b0;
            state      <= WAIT_START_RESP;
          end
        end

        WAIT_START_RESP: begin
          if (start_resp) begin
            state <= CAL_WAIT;
            cnt   <= '0;
          end
        end

        CAL_WAIT: begin
          if (cnt == CNT_LAST) begin
            state              <= SEND_END_REQ;
            o_sideband_message <= MSG_END_REQ;
            if (i_valid_rx) pending    <= 1'b1;
            else            o_valid_tx <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SEND_END_REQ: begin
          if (own_busy) begin
            o_valid_tx <= 1'b0;
            state      <= WAIT_END_RESP;
          end
        end

        WAIT_END_RESP: begin
          if (end_resp) begin
            state              <= TEST_FINISHED;
            o_test_ack         <= 1'b1;
            o_sideband_message <= MSG_NONE;
          end
        end

        TEST_FINISHED: begin
          state <= TEST_FINISHED;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
